// File: rtl/aes_pkg.sv
// AES SubBytes support package: state/byte types, engine FSM encoding and the
// FIPS-197 forward and inverse S-box tables.
// Build option: AES_INV_SBOX_EN compiles in the inverse table.
package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    // Forward S-box
    function automatic aes_byte_t sbox(input aes_byte_t b);
        case (b)
            8'h00: return 8'h63; 8'h01: return 8'h7c; 8'h02: return 8'h77; 8'h03: return 8'h7b;
            8'h04: return 8'hf2; 8'h05: return 8'h6b; 8'h06: return 8'h6f; 8'h07: return 8'hc5;
            8'h08: return 8'h30; 8'h09: return 8'h01; 8'h0a: return 8'h67; 8'h0b: return 8'h2b;
            8'h0c: return 8'hfe; 8'h0d: return 8'hd7; 8'h0e: return 8'hab; 8'h0f: return 8'h76;
            8'h10: return 8'hca; 8'h11: return 8'h82; 8'h12: return 8'hc9; 8'h13: return 8'h7d;
            8'h14: return 8'hfa; 8'h15: return 8'h59; 8'h16: return 8'h47; 8'h17: return 8'hf0;
            8'h18: return 8'had; 8'h19: return 8'hd4; 8'h1a: return 8'ha2; 8'h1b: return 8'haf;
            8'h1c: return 8'h9c; 8'h1d: return 8'ha4; 8'h1e: return 8'h72; 8'h1f: return 8'hc0;
            8'h20: return 8'hb7; 8'h21: return 8'hfd; 8'h22: return 8'h93; 8'h23: return 8'h26;
            8'h24: return 8'h36; 8'h25: return 8'h3f; 8'h26: return 8'hf7; 8'h27: return 8'hcc;
            8'h28: return 8'h34; 8'h29: return 8'ha5; 8'h2a: return 8'he5; 8'h2b: return 8'hf1;
            8'h2c: return 8'h71; 8'h2d: return 8'hd8; 8'h2e: return 8'h31; 8'h2f: return 8'h15;
            8'h30: return 8'h04; 8'h31: return 8'hc7; 8'h32: return 8'h23; 8'h33: return 8'hc3;
            8'h34: return 8'h18; 8'h35: return 8'h96; 8'h36: return 8'h05; 8'h37: return 8'h9a;
            8'h38: return 8'h07; 8'h39: return 8'h12; 8'h3a: return 8'h80; 8'h3b: return 8'he2;
            8'h3c: return 8'heb; 8'h3d: return 8'h27; 8'h3e: return 8'hb2; 8'h3f: return 8'h75;
            8'h40: return 8'h09; 8'h41: return 8'h83; 8'h42: return 8'h2c; 8'h43: return 8'h1a;
            8'h44: return 8'h1b; 8'h45: return 8'h6e; 8'h46: return 8'h5a; 8'h47: return 8'ha0;
            8'h48: return 8'h52; 8'h49: return 8'h3b; 8'h4a: return 8'hd6; 8'h4b: return 8'hb3;
            8'h4c: return 8'h29; 8'h4d: return 8'he3; 8'h4e: return 8'h2f; 8'h4f: return 8'h84;
            8'h50: return 8'h53; 8'h51: return 8'hd1; 8'h52: return 8'h00; 8'h53: return 8'hed;
            8'h54: return 8'h20; 8'h55: return 8'hfc; 8'h56: return 8'hb1; 8'h57: return 8'h5b;
            8'h58: return 8'h6a; 8'h59: return 8'hcb; 8'h5a: return 8'hbe; 8'h5b: return 8'h39;
            8'h5c: return 8'h4a; 8'h5d: return 8'h4c; 8'h5e: return 8'h58; 8'h5f: return 8'hcf;
            8'h60: return 8'hd0; 8'h61: return 8'hef; 8'h62: return 8'haa; 8'h63: return 8'hfb;
            8'h64: return 8'h43; 8'h65: return 8'h4d; 8'h66: return 8'h33; 8'h67: return 8'h85;
            8'h68: return 8'h45; 8'h69: return 8'hf9; 8'h6a: return 8'h02; 8'h6b: return 8'h7f;
            8'h6c: return 8'h50; 8'h6d: return 8'h3c; 8'h6e: return 8'h9f; 8'h6f: return 8'ha8;
            8'h70: return 8'h51; 8'h71: return 8'ha3; 8'h72: return 8'h40; 8'h73: return 8'h8f;
            8'h74: return 8'h92; 8'h75: return 8'h9d; 8'h76: return 8'h38; 8'h77: return 8'hf5;
            8'h78: return 8'hbc; 8'h79: return 8'hb6; 8'h7a: return 8'hda; 8'h7b: return 8'h21;
            8'h7c: return 8'h10; 8'h7d: return 8'hff; 8'h7e: return 8'hf3; 8'h7f: return 8'hd2;
            8'h80: return 8'hcd; 8'h81: return 8'h0c; 8'h82: return 8'h13; 8'h83: return 8'hec;
            8'h84: return 8'h5f; 8'h85: return 8'h97; 8'h86: return 8'h44; 8'h87: return 8'h17;
            8'h88: return 8'hc4; 8'h89: return 8'ha7; 8'h8a: return 8'h7e; 8'h8b: return 8'h3d;
            8'h8c: return 8'h64; 8'h8d: return 8'h5d; 8'h8e: return 8'h19; 8'h8f: return 8'h73;
            8'h90: return 8'h60; 8'h91: return 8'h81; 8'h92: return 8'h4f; 8'h93: return 8'hdc;
            8'h94: return 8'h22; 8'h95: return 8'h2a; 8'h96: return 8'h90; 8'h97: return 8'h88;
            8'h98: return 8'h46; 8'h99: return 8'hee; 8'h9a: return 8'hb8; 8'h9b: return 8'h14;
            8'h9c: return 8'hde; 8'h9d: return 8'h5e; 8'h9e: return 8'h0b; 8'h9f: return 8'hdb;
            8'ha0: return 8'he0; 8'ha1: return 8'h32; 8'ha2: return 8'h3a; 8'ha3: return 8'h0a;
            8'ha4: return 8'h49; 8'ha5: return 8'h06; 8'ha6: return 8'h24; 8'ha7: return 8'h5c;
            8'ha8: return 8'hc2; 8'ha9: return 8'hd3; 8'haa: return 8'hac; 8'hab: return 8'h62;
            8'hac: return 8'h91; 8'had: return 8'h95; 8'hae: return 8'he4; 8'haf: return 8'h79;
            8'hb0: return 8'he7; 8'hb1: return 8'hc8; 8'hb2: return 8'h37; 8'hb3: return 8'h6d;
            8'hb4: return 8'h8d; 8'hb5: return 8'hd5; 8'hb6: return 8'h4e; 8'hb7: return 8'ha9;
            8'hb8: return 8'h6c; 8'hb9: return 8'h56; 8'hba: return 8'hf4; 8'hbb: return 8'hea;
            8'hbc: return 8'h65; 8'hbd: return 8'h7a; 8'hbe: return 8'hae; 8'hbf: return 8'h08;
            8'hc0: return 8'hba; 8'hc1: return 8'h78; 8'hc2: return 8'h25; 8'hc3: return 8'h2e;
            8'hc4: return 8'h1c; 8'hc5: return 8'ha6; 8'hc6: return 8'hb4; 8'hc7: return 8'hc6;
            8'hc8: return 8'he8; 8'hc9: return 8'hdd; 8'hca: return 8'h74; 8'hcb: return 8'h1f;
            8'hcc: return 8'h4b; 8'hcd: return 8'hbd; 8'hce: return 8'h8b; 8'hcf: return 8'h8a;
            8'hd0: return 8'h70; 8'hd1: return 8'h3e; 8'hd2: return 8'hb5; 8'hd3: return 8'h66;
            8'hd4: return 8'h48; 8'hd5: return 8'h03; 8'hd6: return 8'hf6; 8'hd7: return 8'h0e;
            8'hd8: return 8'h61; 8'hd9: return 8'h35; 8'hda: return 8'h57; 8'hdb: return 8'hb9;
            8'hdc: return 8'h86; 8'hdd: return 8'hc1; 8'hde: return 8'h1d; 8'hdf: return 8'h9e;
            8'he0: return 8'he1; 8'he1: return 8'hf8; 8'he2: return 8'h98; 8'he3: return 8'h11;
            8'he4: return 8'h69; 8'he5: return 8'hd9; 8'he6: return 8'h8e; 8'he7: return 8'h94;
            8'he8: return 8'h9b; 8'he9: return 8'h1e; 8'hea: return 8'h87; 8'heb: return 8'he9;
            8'hec: return 8'hce; 8'hed: return 8'h55; 8'hee: return 8'h28; 8'hef: return 8'hdf;
            8'hf0: return 8'h8c; 8'hf1: return 8'ha1; 8'hf2: return 8'h89; 8'hf3: return 8'h0d;
            8'hf4: return 8'hbf; 8'hf5: return 8'he6; 8'hf6: return 8'h42; 8'hf7: return 8'h68;
            8'hf8: return 8'h41; 8'hf9: return 8'h99; 8'hfa: return 8'h2d; 8'hfb: return 8'h0f;
            8'hfc: return 8'hb0; 8'hfd: return 8'h54; 8'hfe: return 8'hbb; 8'hff: return 8'h16;
            default: return 8'h00;
        endcase
    endfunction

`ifdef AES_INV_SBOX_EN
    // Inverse S-box
    function automatic aes_byte_t inv_sbox(input aes_byte_t b);
        case (b)
            8'h00: return 8'h52; 8'h01: return 8'h09; 8'h02: return 8'h6a; 8'h03: return 8'hd5;
            8'h04: return 8'h30; 8'h05: return 8'h36; 8'h06: return 8'ha5; 8'h07: return 8'h38;
            8'h08: return 8'hbf; 8'h09: return 8'h40; 8'h0a: return 8'ha3; 8'h0b: return 8'h9e;
            8'h0c: return 8'h81; 8'h0d: return 8'hf3; 8'h0e: return 8'hd7; 8'h0f: return 8'hfb;
            8'h10: return 8'h7c; 8'h11: return 8'he3; 8'h12: return 8'h39; 8'h13: return 8'h82;
            8'h14: return 8'h9b; 8'h15: return 8'h2f; 8'h16: return 8'hff; 8'h17: return 8'h87;
            8'h18: return 8'h34; 8'h19: return 8'h8e; 8'h1a: return 8'h43; 8'h1b: return 8'h44;
            8'h1c: return 8'hc4; 8'h1d: return 8'hde; 8'h1e: return 8'he9; 8'h1f: return 8'hcb;
            8'h20: return 8'h54; 8'h21: return 8'h7b; 8'h22: return 8'h94; 8'h23: return 8'h32;
            8'h24: return 8'ha6; 8'h25: return 8'hc2; 8'h26: return 8'h23; 8'h27: return 8'h3d;
            8'h28: return 8'hee; 8'h29: return 8'h4c; 8'h2a: return 8'h95; 8'h2b: return 8'h0b;
            8'h2c: return 8'h42; 8'h2d: return 8'hfa; 8'h2e: return 8'hc3; 8'h2f: return 8'h4e;
            8'h30: return 8'h08; 8'h31: return 8'h2e; 8'h32: return 8'ha1; 8'h33: return 8'h66;
            8'h34: return 8'h28; 8'h35: return 8'hd9; 8'h36: return 8'h24; 8'h37: return 8'hb2;
            8'h38: return 8'h76; 8'h39: return 8'h5b; 8'h3a: return 8'ha2; 8'h3b: return 8'h49;
            8'h3c: return 8'h6d; 8'h3d: return 8'h8b; 8'h3e: return 8'hd1; 8'h3f: return 8'h25;
            8'h40: return 8'h72; 8'h41: return 8'hf8; 8'h42: return 8'hf6; 8'h43: return 8'h64;
            8'h44: return 8'h86; 8'h45: return 8'h68; 8'h46: return 8'h98; 8'h47: return 8'h16;
            8'h48: return 8'hd4; 8'h49: return 8'ha4; 8'h4a: return 8'h5c; 8'h4b: return 8'hcc;
            8'h4c: return 8'h5d; 8'h4d: return 8'h65; 8'h4e: return 8'hb6; 8'h4f: return 8'h92;
            8'h50: return 8'h6c; 8'h51: return 8'h70; 8'h52: return 8'h48; 8'h53: return 8'h50;
            8'h54: return 8'hfd; 8'h55: return 8'hed; 8'h56: return 8'hb9; 8'h57: return 8'hda;
            8'h58: return 8'h5e; 8'h59: return 8'h15; 8'h5a: return 8'h46; 8'h5b: return 8'h57;
            8'h5c: return 8'ha7; 8'h5d: return 8'h8d; 8'h5e: return 8'h9d; 8'h5f: return 8'h84;
            8'h60: return 8'h90; 8'h61: return 8'hd8; 8'h62: return 8'hab; 8'h63: return 8'h00;
            8'h64: return 8'h8c; 8'h65: return 8'hbc; 8'h66: return 8'hd3; 8'h67: return 8'h0a;
            8'h68: return 8'hf7; 8'h69: return 8'he4; 8'h6a: return 8'h58; 8'h6b: return 8'h05;
            8'h6c: return 8'hb8; 8'h6d: return 8'hb3; 8'h6e: return 8'h45; 8'h6f: return 8'h06;
            8'h70: return 8'hd0; 8'h71: return 8'h2c; 8'h72: return 8'h1e; 8'h73: return 8'h8f;
            8'h74: return 8'hca; 8'h75: return 8'h3f; 8'h76: return 8'h0f; 8'h77: return 8'h02;
            8'h78: return 8'hc1; 8'h79: return 8'haf; 8'h7a: return 8'hbd; 8'h7b: return 8'h03;
            8'h7c: return 8'h01; 8'h7d: return 8'h13; 8'h7e: return 8'h8a; 8'h7f: return 8'h6b;
            8'h80: return 8'h3a; 8'h81: return 8'h91; 8'h82: return 8'h11; 8'h83: return 8'h41;
            8'h84: return 8'h4f; 8'h85: return 8'h67; 8'h86: return 8'hdc; 8'h87: return 8'hea;
            8'h88: return 8'h97; 8'h89: return 8'hf2; 8'h8a: return 8'hcf; 8'h8b: return 8'hce;
            8'h8c: return 8'hf0; 8'h8d: return 8'hb4; 8'h8e: return 8'he6; 8'h8f: return 8'h73;
            8'h90: return 8'h96; 8'h91: return 8'hac; 8'h92: return 8'h74; 8'h93: return 8'h22;
            8'h94: return 8'he7; 8'h95: return 8'had; 8'h96: return 8'h35; 8'h97: return 8'h85;
            8'h98: return 8'he2; 8'h99: return 8'hf9; 8'h9a: return 8'h37; 8'h9b: return 8'he8;
            8'h9c: return 8'h1c; 8'h9d: return 8'h75; 8'h9e: return 8'hdf; 8'h9f: return 8'h6e;
            8'ha0: return 8'h47; 8'ha1: return 8'hf1; 8'ha2: return 8'h1a; 8'ha3: return 8'h71;
            8'ha4: return 8'h1d; 8'ha5: return 8'h29; 8'ha6: return 8'hc5; 8'ha7: return 8'h89;
            8'ha8: return 8'h6f; 8'ha9: return 8'hb7; 8'haa: return 8'h62; 8'hab: return 8'h0e;
            8'hac: return 8'haa; 8'had: return 8'h18; 8'hae: return 8'hbe; 8'haf: return 8'h1b;
            8'hb0: return 8'hfc; 8'hb1: return 8'h56; 8'hb2: return 8'h3e; 8'hb3: return 8'h4b;
            8'hb4: return 8'hc6; 8'hb5: return 8'hd2; 8'hb6: return 8'h79; 8'hb7: return 8'h20;
            8'hb8: return 8'h9a; 8'hb9: return 8'hdb; 8'hba: return 8'hc0; 8'hbb: return 8'hfe;
            8'hbc: return 8'h78; 8'hbd: return 8'hcd; 8'hbe: return 8'h5a; 8'hbf: return 8'hf4;
            8'hc0: return 8'h1f; 8'hc1: return 8'hdd; 8'hc2: return 8'ha8; 8'hc3: return 8'h33;
            8'hc4: return 8'h88; 8'hc5: return 8'h07; 8'hc6: return 8'hc7; 8'hc7: return 8'h31;
            8'hc8: return 8'hb1; 8'hc9: return 8'h12; 8'hca: return 8'h10; 8'hcb: return 8'h59;
            8'hcc: return 8'h27; 8'hcd: return 8'h80; 8'hce: return 8'hec; 8'hcf: return 8'h5f;
            8'hd0: return 8'h60; 8'hd1: return 8'h51; 8'hd2: return 8'h7f; 8'hd3: return 8'ha9;
            8'hd4: return 8'h19; 8'hd5: return 8'hb5; 8'hd6: return 8'h4a; 8'hd7: return 8'h0d;
            8'hd8: return 8'h2d; 8'hd9: return 8'he5; 8'hda: return 8'h7a; 8'hdb: return 8'h9f;
            8'hdc: return 8'h93; 8'hdd: return 8'hc9; 8'hde: return 8'h9c; 8'hdf: return 8'hef;
            8'he0: return 8'ha0; 8'he1: return 8'he0; 8'he2: return 8'h3b; 8'he3: return 8'h4d;
            8'he4: return 8'hae; 8'he5: return 8'h2a; 8'he6: return 8'hf5; 8'he7: return 8'hb0;
            8'he8: return 8'hc8; 8'he9: return 8'heb; 8'hea: return 8'hbb; 8'heb: return 8'h3c;
            8'hec: return 8'h83; 8'hed: return 8'h53; 8'hee: return 8'h99; 8'hef: return 8'h61;
            8'hf0: return 8'h17; 8'hf1: return 8'h2b; 8'hf2: return 8'h04; 8'hf3: return 8'h7e;
            8'hf4: return 8'hba; 8'hf5: return 8'h77; 8'hf6: return 8'hd6; 8'hf7: return 8'h26;
            8'hf8: return 8'he1; 8'hf9: return 8'h69; 8'hfa: return 8'h14; 8'hfb: return 8'h63;
            8'hfc: return 8'h55; 8'hfd: return 8'h21; 8'hfe: return 8'h0c; 8'hff: return 8'h7d;
            default: return 8'h00;
        endcase
    endfunction
`endif

endpackage

// File: rtl/sbox_lane.sv
// Single-byte combinational S-box lookup, forward or inverse.
// Build option: AES_INV_SBOX_EN enables the inverse path; otherwise i_inv is ignored.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_inv,
    output logic [7:0] o_byte
);

`ifdef AES_INV_SBOX_EN
    // Direction picked per lookup by the latched mode bit
    always_comb begin
        o_byte = i_inv ? inv_sbox(i_byte) : sbox(i_byte);
    end
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;

    // Encrypt-only build: forward table alone
    always_comb begin
        o_byte = sbox(i_byte);
    end
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes / InvSubBytes engine with valid/ready on both sides.
// LANES bytes are substituted per cycle; a block takes NCYC = 16/LANES cycles.
// Build option: AES_INV_SBOX_EN enables InvSubBytes via in_inv.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NCYC  = AES_BYTES / LANES;
    localparam int unsigned CW    = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int unsigned LOG2L = $clog2(LANES);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic         r_inv;
    aes_byte_t    r_work [AES_BYTES];

    aes_byte_t    w_in_bytes [AES_BYTES];
    aes_byte_t    w_lane_in  [LANES];
    aes_byte_t    w_lane_out [LANES];
    logic [3:0]   w_base;
    logic         w_accept;
    logic         w_mode;

    for (genvar k = 0; k < AES_BYTES; k++) begin : g_bytes
        assign w_in_bytes[k]       = in_state[8*k +: 8];
        assign out_state[8*k +: 8] = r_work[k];
    end

`ifdef AES_INV_SBOX_EN
    assign w_mode = in_inv;
`else
    logic w_unused_in_inv;
    assign w_unused_in_inv = in_inv;
    assign w_mode          = 1'b0;
`endif

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY);
    assign w_accept  = in_valid && in_ready;

    // First byte of the current lane group; LANES is a power of two
    assign w_base = 4'(r_cnt) << LOG2L;

    // Route the current lane group of the working register into the lookups
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_lane_in[j] = r_work[w_base + 4'(j)];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sbox_lane u_lane (
            .i_byte (w_lane_in[j]),
            .i_inv  (r_inv),
            .o_byte (w_lane_out[j])
        );
    end

    // FSM, byte counter and working register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            for (int k = 0; k < AES_BYTES; k++) begin
                r_work[k] <= 8'h00;
            end
        end else if (w_accept) begin
            // Covers both IDLE and the DONE overlap with an output handshake
            r_state <= BUSY;
            r_cnt   <= '0;
            r_inv   <= w_mode;
            for (int k = 0; k < AES_BYTES; k++) begin
                r_work[k] <= w_in_bytes[k];
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                end
                BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        r_work[w_base + 4'(j)] <= w_lane_out[j];
                    end
                    if (r_cnt == CW'(NCYC - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: four instances (LANES 1, 2, 4, 16)
// driven with directed vectors. Sweep expectations come from an arithmetic
// GF(2^8) S-box model, independent of the RTL tables.
module tb_sub_bytes_engine;

    localparam int NI = 4;
    localparam int unsigned LANES_TBL [NI] = '{1, 2, 4, 16};

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NI-1:0]         in_valid;
    wire  [NI-1:0]         in_ready;
    logic [NI-1:0][127:0]  in_state;
    logic [NI-1:0]         in_inv;
    wire  [NI-1:0]         out_valid;
    logic [NI-1:0]         out_ready;
    wire  [NI-1:0][127:0]  out_state;
    wire  [NI-1:0]         busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_engine #(.LANES(LANES_TBL[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] r, s;
        r = 8'h01;
        if (x == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, x);
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] st);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox_ref(st[8*k +: 8]);
        return o;
    endfunction

    // Present a block and wait for the accept edge; inputs are scrambled afterwards
    task automatic send(input int idx, input logic [127:0] st, input logic inv);
        int n;
        n = 0;
        in_state[idx] = st;
        in_inv[idx]   = inv;
        in_valid[idx] = 1'b1;
        while (!in_ready[idx] && n < 64) begin
            tick();
            n++;
        end
        check("accept_ready", {127'd0, in_ready[idx]}, 128'd1);
        tick();
        in_valid[idx] = 1'b0;
        in_state[idx] = ~st;
        in_inv[idx]   = ~inv;
    endtask

    task automatic wait_done(input int idx, input int exp_cyc, input string tag);
        int n;
        n = 0;
        while (!out_valid[idx] && n < 64) begin
            tick();
            n++;
        end
        check(tag, 128'(n), 128'(exp_cyc));
    endtask

    task automatic drain(input int idx);
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
        check("drain_valid_low", {127'd0, out_valid[idx]}, 128'd0);
    endtask

    logic [127:0] res [16];
    logic [127:0] blk;
    logic [127:0] exp_v;
    int           stale;

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_state  = '0;
        in_inv    = '0;
        out_ready = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state of every instance
        for (int i = 0; i < NI; i++) begin
            check("rst_in_ready",  {127'd0, in_ready[i]},  128'd1);
            check("rst_out_valid", {127'd0, out_valid[i]}, 128'd0);
            check("rst_busy",      {127'd0, busy[i]},      128'd0);
            check("rst_out_state", out_state[i],           128'd0);
        end

        // FIPS-197 round-1 SubBytes, LANES=4
        send(2, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
        check("l4_busy", {127'd0, busy[2]}, 128'd1);
        wait_done(2, 4, "l4_latency");
        check("l4_fips_fwd", out_state[2], 128'hd42711aee0bf98f1b8b45de51e415230);
        drain(2);

        // Reset while cnt==1 discards the block
        send(2, 128'h00112233445566778899aabbccddeeff, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", {127'd0, out_valid[2]}, 128'd0);
        check("mid_rst_out_state", out_state[2],           128'd0);
        check("mid_rst_in_ready",  {127'd0, in_ready[2]},  128'd1);
        check("mid_rst_busy",      {127'd0, busy[2]},      128'd0);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid[2] || out_state[2] != 128'd0) stale++;
        end
        check("mid_rst_no_stale", 128'(stale), 128'd0);

        // LANES=16: inverse vector and all-zero forward, one-cycle latency
        send(3, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1);
        wait_done(3, 1, "l16_latency_inv");
`ifdef AES_INV_SBOX_EN
        exp_v = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`else
        exp_v = fwd_state(128'hd42711aee0bf98f1b8b45de51e415230);
`endif
        check("l16_inv", out_state[3], exp_v);
        drain(3);
        send(3, 128'd0, 1'b0);
        wait_done(3, 1, "l16_latency_zero");
        check("l16_zero", out_state[3], {16{8'h63}});
        drain(3);

        // LANES=1 backpressure then overlapped handshake + accept
        send(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
        wait_done(0, 16, "l1_latency_a");
        for (int c = 0; c < 10; c++) begin
            check("bp_hold_state", out_state[0], 128'hd42711aee0bf98f1b8b45de51e415230);
            check("bp_in_ready",   {127'd0, in_ready[0]}, 128'd0);
            tick();
        end
        in_state[0]  = 128'h0f0e0d0c0b0a09080706050403020100;
        in_inv[0]    = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        check("overlap_in_ready", {127'd0, in_ready[0]}, 128'd1);
        tick();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        in_state[0]  = '1;
        check("overlap_busy",      {127'd0, busy[0]},      128'd1);
        check("overlap_out_valid", {127'd0, out_valid[0]}, 128'd0);
        wait_done(0, 16, "l1_latency_b");
        check("l1_row0", out_state[0], 128'h76abd7fe2b670130c56f6bf27b777c63);
        drain(0);

        // LANES=2 byte sweep: forward, then inverse of each result
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(b * 16 + k);
            send(1, blk, 1'b0);
            wait_done(1, 8, "l2_latency_fwd");
            res[b] = out_state[1];
            check("sweep_fwd", res[b], fwd_state(blk));
            drain(1);
        end
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(b * 16 + k);
            send(1, res[b], 1'b1);
            wait_done(1, 8, "l2_latency_inv");
`ifdef AES_INV_SBOX_EN
            exp_v = blk;
`else
            exp_v = fwd_state(res[b]);
`endif
            check("sweep_inv", out_state[1], exp_v);
            drain(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
